// File: rtl/object_engine.sv
// Moving-object manager: N_OBJ bouncing boxes, one advanced per clock
// after refresh_tick, player-overlap retirement and per-pixel coverage.
module object_engine #(
  parameter int N_OBJ       = 16,
  parameter int OBJ_SIZE    = 16,
  parameter int PLAYER_SIZE = 20,
  parameter int H_MAX       = 640,
  parameter int V_MAX       = 480,
  parameter int VW          = 4
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  input  logic                       refresh_tick,
  input  logic [9:0]                 player_x,
  input  logic [9:0]                 player_y,
  input  logic                       spawn_valid,
  output logic                       spawn_ready,
  input  logic [9:0]                 spawn_x,
  input  logic [9:0]                 spawn_y,
  input  logic signed [VW-1:0]       spawn_dx,
  input  logic signed [VW-1:0]       spawn_dy,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  input  logic                       video_on,
  output logic                       pix_on,
  output logic [$clog2(N_OBJ)-1:0]   pix_id,
  output logic                       hit_pulse,
  output logic [$clog2(N_OBJ)-1:0]   hit_id,
  output logic [$clog2(N_OBJ):0]     active_count,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int IW = $clog2(N_OBJ);
  localparam logic [9:0] XMAX = 10'(H_MAX - OBJ_SIZE);
  localparam logic [9:0] YMAX = 10'(V_MAX - OBJ_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [N_OBJ-1:0]  active;
  logic [9:0]        obj_x  [N_OBJ];
  logic [9:0]        obj_y  [N_OBJ];
  logic [VW-1:0]     obj_dx [N_OBJ];
  logic [VW-1:0]     obj_dy [N_OBJ];

  // Negating the most-negative velocity saturates instead of wrapping.
  function automatic logic [VW-1:0] neg_sat(input logic [VW-1:0] d);
    if (d == {1'b1, {(VW-1){1'b0}}})
      return {1'b0, {(VW-1){1'b1}}};
    return -d;
  endfunction

  function automatic logic [10+VW-1:0] axis_step(
    input logic [9:0]    p,
    input logic [VW-1:0] d,
    input logic [9:0]    lim
  );
    logic signed [11:0] n;
    n = $signed({2'b00, p}) + $signed({{(12-VW){d[VW-1]}}, d});
    if (n[11])
      return {10'd0, neg_sat(d)};
    else if (n > $signed({2'b00, lim}))
      return {lim, neg_sat(d)};
    return {n[9:0], d};
  endfunction

  logic          free_found;
  logic [IW-1:0] free_id;

  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_id    = IW'(i);
      end
    end
  end

  assign spawn_ready = !reset && (state == IDLE) && free_found;

  logic       spawn_fire;
  logic [9:0] sx, sy;

  assign spawn_fire = spawn_valid && spawn_ready;
  assign sx = (spawn_x > XMAX) ? XMAX : spawn_x;
  assign sy = (spawn_y > YMAX) ? YMAX : spawn_y;

  logic [10+VW-1:0] step_x, step_y;
  logic [9:0]       nx, ny;
  logic [VW-1:0]    ndx, ndy;
  logic             hit;

  assign step_x = axis_step(obj_x[idx], obj_dx[idx], XMAX);
  assign step_y = axis_step(obj_y[idx], obj_dy[idx], YMAX);
  assign {nx, ndx} = step_x;
  assign {ny, ndy} = step_y;

  // Half-open boxes: touching edges do not overlap.
  assign hit = active[idx]
    && (12'(nx) < 12'(player_x) + 12'(PLAYER_SIZE))
    && (12'(player_x) < 12'(nx) + 12'(OBJ_SIZE))
    && (12'(ny) < 12'(player_y) + 12'(PLAYER_SIZE))
    && (12'(player_y) < 12'(ny) + 12'(OBJ_SIZE));

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      active       <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      hit_pulse    <= 1'b0;
      hit_id       <= '0;
      active_count <= '0;
      overrun      <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        obj_x[i]  <= '0;
        obj_y[i]  <= '0;
        obj_dx[i] <= '0;
        obj_dy[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      hit_pulse  <= 1'b0;
      if (spawn_fire) begin
        obj_x[free_id]  <= sx;
        obj_y[free_id]  <= sy;
        obj_dx[free_id] <= spawn_dx;
        obj_dy[free_id] <= spawn_dy;
        active[free_id] <= 1'b1;
        active_count    <= active_count + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (refresh_tick) begin
            state <= UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          if (refresh_tick)
            overrun <= 1'b1;
          if (active[idx]) begin
            obj_x[idx]  <= nx;
            obj_y[idx]  <= ny;
            obj_dx[idx] <= ndx;
            obj_dy[idx] <= ndy;
          end
          if (hit) begin
            active[idx]  <= 1'b0;
            hit_pulse    <= 1'b1;
            hit_id       <= idx;
            active_count <= active_count - 1'b1;
          end
          if (idx == IW'(N_OBJ - 1)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (refresh_tick)
            overrun <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic          pix_hit;
  logic [IW-1:0] pix_sel;

  always_comb begin
    pix_hit = 1'b0;
    pix_sel = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (active[i]
          && (x >= obj_x[i])
          && (11'(x) < 11'(obj_x[i]) + 11'(OBJ_SIZE))
          && (y >= obj_y[i])
          && (11'(y) < 11'(obj_y[i]) + 11'(OBJ_SIZE))) begin
        pix_hit = 1'b1;
        pix_sel = IW'(i);
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      pix_on <= 1'b0;
      pix_id <= '0;
    end else begin
      pix_on <= video_on && pix_hit;
      pix_id <= (video_on && pix_hit) ? pix_sel : '0;
    end
  end

endmodule
